dmem_slave: RTL and testbench

Data-memory responder on the core's data request bus. It is the target end of the req/gnt/valid protocol driven by the load/store unit.
Accepts byte-enabled reads and writes into an internal word-organised SRAM model, with a programmable number of grant wait states. Returns one in-order response per grant, exactly one cycle after the grant.
Used as the data memory in core-level simulation and FPGA builds, and as the stress target for unaligned split accesses.

---
 rtl/dmem_slave.sv | 232 +++++++++++++++++++++++
 tb/tb_dmem_slave.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_slave.sv
// -----------------------------------------------------------------------------
// dmem_slave : data-memory responder for the core's req/gnt/valid data bus.
//
// Target end of the load/store-unit protocol. Requests are held by the
// initiator until granted; the access commits at the clock edge that ends the
// grant cycle, and exactly one response (data_valid) follows one cycle later,
// strictly in order. Reads and writes go to an internal word-organised SRAM
// model with per-byte write enables. Out-of-range accesses leave the array
// untouched and respond with data_err=1 and data_rdata=0.
//
// Grant timing:
//   WAIT_CYCLES == 0 : data_gnt follows data_req combinationally.
//   WAIT_CYCLES  > 0 : a small IDLE/WAIT/GRANT FSM raises a registered
//                      data_gnt WAIT_CYCLES cycles after data_req rises.
//
// Optional build macro:
//   DMEM_STALL_LFSR_EN : a 16-bit Fibonacci LFSR suppresses grants on cycles
//                        where lfsr[1:0]==2'b00, inserting random wait states.
//
// Parameters:
//   MEM_WORDS   : number of 32-bit words (power of two)
//   BASE_ADDR   : byte address of word 0 (aligned to MEM_WORDS*4)
//   WAIT_CYCLES : grant wait states per request (0..15)
//
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   data_req       : request valid, held until granted
//   data_wr        : 1 = write, 0 = read
//   data_gnt       : request accepted this cycle
//   data_addr      : byte address ([1:0] ignored for indexing)
//   data_wdata     : lane-aligned write data
//   data_be        : byte enables for writes
//   data_rdata     : read data, qualified by data_valid
//   data_valid     : response strobe, one cycle after the grant
//   data_err       : response error (out of range), qualified by data_valid
// -----------------------------------------------------------------------------
module dmem_slave #(
   parameter int unsigned MEM_WORDS   = 4096,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        data_req,
   input  logic        data_wr,
   output logic        data_gnt,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   input  logic [3:0]  data_be,
   output logic [31:0] data_rdata,
   output logic        data_valid,
   output logic        data_err
);

   localparam int unsigned IDX_W     = $clog2(MEM_WORDS);
   localparam logic [31:0] MEM_SPAN  = 32'(MEM_WORDS * 4);
   localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES - 1);
   localparam logic        WAIT_EN   = 1'(WAIT_CYCLES != 0);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_GRANT = 2'd2
   } state_t;

   state_t             state_r;
   state_t             state_n_s;
   logic [3:0]         cnt_r;
   logic [3:0]         cnt_n_s;
   logic               gnt_r;
   logic               gnt_s;
   logic               fsm_req_s;
   logic               stall_s;

   logic [31:0]        off_s;
   logic               in_range_s;
   logic [IDX_W-1:0]   idx_s;
   logic               access_s;

   logic [31:0]        mem_r [MEM_WORDS];
   logic [31:0]        rd_word_r;
   logic               rd_sel_r;
   logic               valid_r;
   logic               err_r;

   // ---------------------------------------------------------------------------
   // Optional random grant throttling
   // ---------------------------------------------------------------------------
`ifdef DMEM_STALL_LFSR_EN
   logic [15:0] lfsr_r;

   // Free-running Fibonacci LFSR, taps 16,14,13,11.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lfsr_r <= 16'hACE1;
      end else begin
         lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
      end
   end

   assign stall_s = (lfsr_r[1:0] == 2'b00);
`else
   assign stall_s = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // Address decode: modular offset makes addresses below BASE_ADDR wrap to a
   // huge offset, so a single compare covers both ends of the window.
   // ---------------------------------------------------------------------------
   assign off_s      = data_addr - BASE_ADDR;
   assign in_range_s = (off_s < MEM_SPAN);
   assign idx_s      = off_s[IDX_W+1:2];

   // ---------------------------------------------------------------------------
   // Grant generation
   // ---------------------------------------------------------------------------
   // The FSM only sees requests when wait states are configured.
   assign fsm_req_s = data_req & WAIT_EN;

   // Zero-wait mode grants in the request cycle; gating with reset_n keeps
   // data_gnt low while reset is held.
   assign gnt_s    = WAIT_EN ? gnt_r : (data_req & ~stall_s & reset_n);
   assign data_gnt = gnt_s;
   assign access_s = data_req & gnt_s;

   // FSM state, wait counter and registered grant.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= ST_IDLE;
         cnt_r   <= 4'd0;
         gnt_r   <= 1'b0;
      end else begin
         state_r <= state_n_s;
         cnt_r   <= cnt_n_s;
         gnt_r   <= (state_n_s == ST_GRANT);
      end
   end

   // Next-state and counter logic. A stalled grant holds the current state so
   // the grant is retried on the following cycle.
   always_comb begin
      state_n_s = state_r;
      cnt_n_s   = cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (fsm_req_s) begin
               if (WAIT_LOAD == 4'd0) begin
                  cnt_n_s = 4'd0;
                  if (!stall_s) begin
                     state_n_s = ST_GRANT;
                  end else begin
                     state_n_s = ST_IDLE;
                  end
               end else begin
                  cnt_n_s   = WAIT_LOAD;
                  state_n_s = ST_WAIT;
               end
            end else begin
               cnt_n_s   = 4'd0;
               state_n_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (!fsm_req_s) begin
               // Request withdrawn before its grant: abandon without access.
               cnt_n_s   = 4'd0;
               state_n_s = ST_IDLE;
            end else if (cnt_r <= 4'd1) begin
               if (!stall_s) begin
                  cnt_n_s   = 4'd0;
                  state_n_s = ST_GRANT;
               end else begin
                  cnt_n_s   = cnt_r;
                  state_n_s = ST_WAIT;
               end
            end else begin
               cnt_n_s   = cnt_r - 4'd1;
               state_n_s = ST_WAIT;
            end
         end
         ST_GRANT: begin
            cnt_n_s   = 4'd0;
            state_n_s = ST_IDLE;
         end
         default: begin
            cnt_n_s   = 4'd0;
            state_n_s = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Storage
   // ---------------------------------------------------------------------------
   // Byte-lane write into the array; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (access_s && data_wr && in_range_s) begin
         for (int b = 0; b < 4; b++) begin
            if (data_be[b]) begin
               mem_r[idx_s][8*b +: 8] <= data_wdata[8*b +: 8];
            end
         end
      end
   end

   // Synchronous array read, captured every cycle; rd_sel_r decides whether
   // it is presented, so a write or error response returns zero.
   always_ff @(posedge clk) begin
      rd_word_r <= mem_r[idx_s];
   end

   // ---------------------------------------------------------------------------
   // Response
   // ---------------------------------------------------------------------------
   // One response per access, one cycle after the grant edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_r  <= 1'b0;
         err_r    <= 1'b0;
         rd_sel_r <= 1'b0;
      end else begin
         valid_r  <= access_s;
         err_r    <= access_s & ~in_range_s;
         rd_sel_r <= access_s & ~data_wr & in_range_s;
      end
   end

   assign data_valid = valid_r;
   assign data_err   = err_r;
   assign data_rdata = rd_sel_r ? rd_word_r : 32'h0000_0000;

endmodule

// File: tb/tb_dmem_slave.sv
// -----------------------------------------------------------------------------
// tb_dmem_slave : scoreboard bench for dmem_slave.
// Two instances: u_w0 (WAIT_CYCLES=0) and u_w3 (WAIT_CYCLES=3), each with its
// own memory. Drivers push the hand-computed response at the grant edge; a
// negedge monitor pops and compares data, error flag and one-cycle latency.
// -----------------------------------------------------------------------------
module tb_dmem_slave;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n;
   logic        req   [2];
   logic        wr    [2];
   logic [31:0] addr  [2];
   logic [31:0] wdata [2];
   logic [3:0]  be    [2];
   logic [1:0]  gnt;
   logic [1:0]  valid;
   logic [1:0]  err;
   logic [31:0] rdata0;
   logic [31:0] rdata1;

   dmem_slave #(.WAIT_CYCLES(0)) u_w0 (
      .clk(clk), .reset_n(reset_n), .data_req(req[0]), .data_wr(wr[0]),
      .data_gnt(gnt[0]), .data_addr(addr[0]), .data_wdata(wdata[0]),
      .data_be(be[0]), .data_rdata(rdata0), .data_valid(valid[0]), .data_err(err[0])
   );

   dmem_slave #(.WAIT_CYCLES(3)) u_w3 (
      .clk(clk), .reset_n(reset_n), .data_req(req[1]), .data_wr(wr[1]),
      .data_gnt(gnt[1]), .data_addr(addr[1]), .data_wdata(wdata[1]),
      .data_be(be[1]), .data_rdata(rdata1), .data_valid(valid[1]), .data_err(err[1])
   );

   typedef struct packed {
      logic [31:0] rd;
      logic        er;
      logic [31:0] cyc;
   } exp_t;

   exp_t        q0 [$];
   exp_t        q1 [$];
   exp_t        e0;
   exp_t        e1;
   logic [31:0] exp_rd [2];
   logic        exp_er [2];
   logic [31:0] cyc = 32'd0;
   int          checks = 0;
   int          failures = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, want);
      end
   endtask

   // Scoreboard push at every grant edge.
   always @(posedge clk) begin
      if (req[0] && gnt[0]) q0.push_back({exp_rd[0], exp_er[0], cyc});
      if (req[1] && gnt[1]) q1.push_back({exp_rd[1], exp_er[1], cyc});
      cyc = cyc + 32'd1;
   end

   // Monitor: pop and compare whenever a response is presented.
   always @(negedge clk) begin
      if (reset_n) begin
         if (valid[0]) begin
            if (q0.size() == 0) begin
               check("w0_spurious_valid", 32'(valid[0]), 32'd0);
            end else begin
               e0 = q0.pop_front();
               check("w0_rdata", rdata0, e0.rd);
               check("w0_err", 32'(err[0]), 32'(e0.er));
               check("w0_latency", cyc, e0.cyc + 32'd1);
            end
         end else if (q0.size() != 0 && (q0[0].cyc + 32'd1) <= cyc) begin
            check("w0_missing_valid", 32'(valid[0]), 32'd1);
            e0 = q0.pop_front();
         end
         if (valid[1]) begin
            if (q1.size() == 0) begin
               check("w3_spurious_valid", 32'(valid[1]), 32'd0);
            end else begin
               e1 = q1.pop_front();
               check("w3_rdata", rdata1, e1.rd);
               check("w3_err", 32'(err[1]), 32'(e1.er));
               check("w3_latency", cyc, e1.cyc + 32'd1);
            end
         end else if (q1.size() != 0 && (q1[0].cyc + 32'd1) <= cyc) begin
            check("w3_missing_valid", 32'(valid[1]), 32'd1);
            e1 = q1.pop_front();
         end
      end
   end

   // Issue one request on instance d, hold until granted, check grant delay.
   task automatic issue(input int d, input logic w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] b,
                        input logic [31:0] erd, input logic eer, input int nwait);
      int   waited;
      logic ok;
      @(negedge clk);
      req[d] = 1'b1; wr[d] = w; addr[d] = a; wdata[d] = wd; be[d] = b;
      exp_rd[d] = erd; exp_er[d] = eer;
      ok = 1'b0;
      waited = 0;
      for (int i = 0; i < 40; i++) begin
         #1;
         if (gnt[d]) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
         waited++;
      end
      check($sformatf("grant_wait_d%0d_a%h", d, a), 32'(waited), 32'(nwait));
      if (ok) @(posedge clk);
      #1 req[d] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         req[i] = 1'b0; wr[i] = 1'b0; addr[i] = 32'h0; wdata[i] = 32'h0;
         be[i] = 4'h0; exp_rd[i] = 32'h0; exp_er[i] = 1'b0;
      end
      req[0] = 1'b1;
      #2;
      // Reset state (zero-wait grant must stay low while reset is held)
      check("rst_gnt0", 32'(gnt[0]), 32'd0);
      check("rst_gnt1", 32'(gnt[1]), 32'd0);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_rdata0", rdata0, 32'h0);
      check("rst_rdata1", rdata1, 32'h0);
      req[0] = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;

      // 1: zero-wait write then read
      issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 0);
      issue(0, 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0, 0);
      // be=0 write is a no-op
      issue(0, 1'b1, 32'h10, 32'h0, 4'h0, 32'h0, 1'b0, 0);
      issue(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 0);
      // 2: byte lanes
      issue(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0, 1'b0, 0);
      issue(0, 1'b1, 32'h23, 32'hAA000000, 4'b1000, 32'h0, 1'b0, 0);
      issue(0, 1'b0, 32'h20, 32'h0, 4'h0, 32'hAA223344, 1'b0, 0);
      // 3: unaligned split read on consecutive grants
      issue(0, 1'b1, 32'h40, 32'h44332211, 4'hF, 32'h0, 1'b0, 0);
      issue(0, 1'b1, 32'h44, 32'h88776655, 4'hF, 32'h0, 1'b0, 0);
      issue(0, 1'b0, 32'h41, 32'h0, 4'hF, 32'h44332211, 1'b0, 0);
      issue(0, 1'b0, 32'h45, 32'h0, 4'hF, 32'h88776655, 1'b0, 0);
      // 5: out of range, plus last in-range word
      issue(0, 1'b1, 32'h0, 32'h01020304, 4'hF, 32'h0, 1'b0, 0);
      issue(0, 1'b1, 32'h3FFC, 32'h5A5AA5A5, 4'hF, 32'h0, 1'b0, 0);
      issue(0, 1'b0, 32'h4000, 32'h0, 4'hF, 32'h0, 1'b1, 0);
      issue(0, 1'b1, 32'hFFFF_FFFC, 32'h55555555, 4'hF, 32'h0, 1'b1, 0);
      issue(0, 1'b0, 32'h0, 32'h0, 4'hF, 32'h01020304, 1'b0, 0);
      issue(0, 1'b0, 32'h3FFC, 32'h0, 4'hF, 32'h5A5AA5A5, 1'b0, 0);

      // 4: three wait states, back-to-back requests each pay the full wait
      issue(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 3);
      issue(1, 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0, 3);
      // Request withdrawn before grant: no grant, no access
      @(negedge clk);
      req[1] = 1'b1; wr[1] = 1'b1; addr[1] = 32'h10; wdata[1] = 32'h0; be[1] = 4'hF;
      #1 check("abandon_gnt_c0", 32'(gnt[1]), 32'd0);
      @(negedge clk);
      #1 check("abandon_gnt_c1", 32'(gnt[1]), 32'd0);
      @(negedge clk);
      req[1] = 1'b0;
      #1 check("abandon_gnt_c2", 32'(gnt[1]), 32'd0);
      issue(1, 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0, 3);
      issue(1, 1'b0, 32'h4000, 32'h0, 4'hF, 32'h0, 1'b1, 3);

      // 6: reset during WAIT (w3) and with a response pending (w0)
      @(negedge clk);
      req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 32'h100;
      req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h30; wdata[0] = 32'hCAFEF00D; be[0] = 4'hF;
      exp_rd[0] = 32'h0; exp_er[0] = 1'b0;
      @(posedge clk);
      #1;
      check("pre_rst_valid0", 32'(valid[0]), 32'd1);
      reset_n = 1'b0;
      #1;
      check("mid_rst_valid0", 32'(valid[0]), 32'd0);
      check("mid_rst_err0", 32'(err[0]), 32'd0);
      check("mid_rst_gnt0", 32'(gnt[0]), 32'd0);
      check("mid_rst_gnt1", 32'(gnt[1]), 32'd0);
      check("mid_rst_valid1", 32'(valid[1]), 32'd0);
      q0.delete();
      q1.delete();
      req[0] = 1'b0;
      req[1] = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      issue(1, 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0, 3);
      issue(0, 1'b0, 32'h30, 32'h0, 4'hF, 32'hCAFEF00D, 1'b0, 0);

      repeat (4) @(negedge clk);
      check("q0_drained", 32'(q0.size()), 32'd0);
      check("q1_drained", 32'(q1.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
